spin_accum: RTL and testbench

SPIN_ACCUM -- requirements
Module: spin_accum

---
 rtl/spin_accum.sv | 117 +++++++++++
 tb/tb_spin_accum.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spin_accum.sv
// Dial position accumulator: merges two toggle-flagged spinner deltas and a
// strobe-paced joystick key (with hold-to-accelerate) into a wrapping 8-bit position.
module spin_accum #(
    parameter int KEY_STEP    = 3,
    parameter int FAST_STEP   = 6,
    parameter int HOLD_FRAMES = 8,
    parameter int DEV_SHIFT   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       minus,
    input  logic       plus,
    input  logic       fast,
    input  logic       strobe,
    input  logic [8:0] spin1_in,
    input  logic [8:0] spin2_in,
    output logic [7:0] spin_out
);

    localparam int CW = $clog2(HOLD_FRAMES + 1);
    localparam logic [9:0] KEY_DELTA  = 10'(KEY_STEP);
    localparam logic [9:0] FAST_DELTA = 10'(FAST_STEP);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLOW  = 2'd1,
        ACCEL = 2'd2
    } key_state_t;

    logic [8:0]    spin_in [2];
    logic [1:0]    tog_q, tog_d;
    logic [9:0]    dev_delta [2];
    logic          strobe_q, strobe_d;
    key_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_neg_q, dir_neg_d;
    logic [7:0]    pos_q, pos_d;
    logic [9:0]    key_delta;
    logic [9:0]    step;
    logic [9:0]    sum;
    logic          strobe_edge;
    logic          key_active;

    assign spin_in[0] = spin1_in;
    assign spin_in[1] = spin2_in;

    // Each spinner contributes only on the cycle its toggle bit flips.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dev
            assign tog_d[gi] = spin_in[gi][8];
            always_comb begin
                dev_delta[gi] = '0;
                if (spin_in[gi][8] != tog_q[gi]) begin
                    dev_delta[gi] = $signed({{2{spin_in[gi][7]}}, spin_in[gi][7:0]}) >>> DEV_SHIFT;
                end
            end
        end
    endgenerate

    assign strobe_d    = strobe;
    assign strobe_edge = strobe & ~strobe_q;
    assign key_active  = plus ^ minus;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_neg_d = dir_neg_q;
        key_delta = '0;
        step      = KEY_DELTA;
        if (strobe_edge) begin
            if (!key_active) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                dir_neg_d = minus;
                if (state_q == IDLE || minus != dir_neg_q) begin
                    state_d = SLOW;
                    cnt_d   = CW'(1);
                end else if (state_q == ACCEL || cnt_q == HOLD_MAX) begin
                    // Acceleration kicks in on the strobe after the counter reaches the limit.
                    state_d = ACCEL;
                    cnt_d   = HOLD_MAX;
                end else begin
                    state_d = SLOW;
                    cnt_d   = cnt_q + CW'(1);
                end
                step      = (fast || state_d == ACCEL) ? FAST_DELTA : KEY_DELTA;
                key_delta = minus ? (10'd0 - step) : step;
            end
        end
    end

    assign sum   = key_delta + dev_delta[0] + dev_delta[1];
    assign pos_d = pos_q + sum[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            tog_q     <= {spin2_in[8], spin1_in[8]};
            strobe_q  <= strobe;
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_neg_q <= 1'b0;
            pos_q     <= '0;
        end else begin
            tog_q     <= tog_d;
            strobe_q  <= strobe_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_neg_q <= dir_neg_d;
            pos_q     <= pos_d;
        end
    end

    assign spin_out = pos_q;

endmodule

// File: tb/tb_spin_accum.sv
// Randomised and directed bench for spin_accum; a queue-based scoreboard compares
// every cycle's dial position against a hold-count reference model.
module tb_spin_accum;

    localparam int KEY_STEP    = 3;
    localparam int FAST_STEP   = 6;
    localparam int HOLD_FRAMES = 8;
    localparam int DEV_SHIFT   = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       minus = 1'b0;
    logic       plus = 1'b0;
    logic       fast = 1'b0;
    logic       strobe = 1'b0;
    logic [8:0] spin1_in = '0;
    logic [8:0] spin2_in = '0;
    logic [7:0] spin_out;

    int checks = 0;
    int errors = 0;
    bit done = 0;

    int exp_q[$];
    int exp_pos = 0;
    bit tog1 = 0, tog2 = 0, strb_prev = 0;
    int held = 0;
    int last_dir = 0;

    spin_accum #(
        .KEY_STEP(KEY_STEP), .FAST_STEP(FAST_STEP),
        .HOLD_FRAMES(HOLD_FRAMES), .DEV_SHIFT(DEV_SHIFT)
    ) dut (
        .clk(clk), .reset(reset), .minus(minus), .plus(plus), .fast(fast),
        .strobe(strobe), .spin1_in(spin1_in), .spin2_in(spin2_in), .spin_out(spin_out)
    );

    always #5 clk = ~clk;

    // Reference: held counts consecutive same-direction strobes; beyond HOLD_FRAMES is fast.
    task automatic step_cycle();
        int sum;
        int d;
        int dir;
        if (reset) begin
            exp_pos  = 0;
            held     = 0;
            last_dir = 0;
        end else begin
            sum = 0;
            if (spin1_in[8] != tog1) begin
                d = $signed(spin1_in[7:0]);
                sum += d >>> DEV_SHIFT;
            end
            if (spin2_in[8] != tog2) begin
                d = $signed(spin2_in[7:0]);
                sum += d >>> DEV_SHIFT;
            end
            if (strobe && !strb_prev) begin
                dir = (plus && !minus) ? 1 : ((minus && !plus) ? -1 : 0);
                if (dir == 0) held = 0;
                else if (dir == last_dir) held++;
                else held = 1;
                last_dir = dir;
                sum += dir * ((fast || held > HOLD_FRAMES) ? FAST_STEP : KEY_STEP);
            end
            exp_pos = (exp_pos + sum) & 255;
        end
        tog1      = spin1_in[8];
        tog2      = spin2_in[8];
        strb_prev = strobe;
        exp_q.push_back(exp_pos);
        @(negedge clk);
    endtask

    task automatic check_const(input string name, input int want);
        checks++;
        if (spin_out != want[7:0]) begin
            errors++;
            $display("FAIL %s: spin_out=%0d expected %0d", name, spin_out, want);
        end else begin
            $display("check %s: spin_out=%0d", name, spin_out);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; strobe = 1'b0;
        step_cycle();
        reset = 1'b0;
    endtask

    task automatic strobe_pulse(input logic p, input logic m, input logic f, input string name, input int want);
        plus = p; minus = m; fast = f; strobe = 1'b1;
        step_cycle();
        check_const(name, want);
        strobe = 1'b0;
        step_cycle();
    endtask

    // Monitor: every clock the DUT presents a new position; compare against the scoreboard.
    initial begin
        int want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checks++;
                if (spin_out != want[7:0]) begin
                    errors++;
                    $display("FAIL scoreboard @%0t: spin_out=%0d expected %0d", $time, spin_out, want);
                end
            end
        end
    end

    initial begin
        int seq [10] = '{3, 6, 9, 12, 15, 18, 21, 24, 30, 36};
        spin1_in = 9'h155; spin2_in = 9'h0AA;
        repeat (3) step_cycle();
        reset = 1'b0;
        step_cycle();
        check_const("reset_release", 0);

        // Single device event, then static inputs
        spin1_in = {~spin1_in[8], 8'h10};
        step_cycle();
        check_const("dev1_event", 8'h08);
        repeat (3) step_cycle();
        check_const("dev1_static", 8'h08);

        // Hold-to-accelerate sequence and reversal
        do_reset();
        for (int i = 0; i < 10; i++) strobe_pulse(1'b1, 1'b0, 1'b0, $sformatf("hold_%0d", i + 1), seq[i]);
        strobe_pulse(1'b0, 1'b1, 1'b0, "reverse_1", 33);
        strobe_pulse(1'b0, 1'b1, 1'b0, "reverse_2", 30);

        // Reset while accelerating with key still held
        do_reset();
        for (int i = 0; i < 9; i++) strobe_pulse(1'b1, 1'b0, 1'b0, "accel_setup", seq[i]);
        plus = 1'b1; reset = 1'b1;
        step_cycle();
        check_const("reset_in_accel", 0);
        reset = 1'b0;
        step_cycle();
        check_const("release_no_event", 0);
        strobe_pulse(1'b1, 1'b0, 1'b0, "restart_slow", 3);

        // Wrap below zero, then both keys held
        do_reset();
        plus = 1'b0;
        spin1_in = {~spin1_in[8], 8'h04};
        step_cycle();
        check_const("preset_02", 2);
        strobe_pulse(1'b0, 1'b1, 1'b0, "wrap_down", 8'hFF);
        for (int i = 0; i < 5; i++) strobe_pulse(1'b1, 1'b1, 1'b0, "both_keys", 8'hFF);
        strobe_pulse(1'b1, 1'b0, 1'b0, "wrap_up", 2);

        // Simultaneous key, device 1 and device 2 events
        do_reset();
        plus = 1'b0; minus = 1'b0;
        spin1_in = {~spin1_in[8], 8'h7E};
        spin2_in = {~spin2_in[8], 8'h02};
        step_cycle();
        check_const("preset_40", 8'h40);
        spin1_in = {~spin1_in[8], 8'hF0};
        spin2_in = {~spin2_in[8], 8'h04};
        strobe_pulse(1'b1, 1'b0, 1'b1, "simultaneous", 8'h40);
        strobe_pulse(1'b1, 1'b0, 1'b1, "fast_button", 8'h46);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            reset  = ($urandom_range(0, 299) == 0);
            strobe = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) begin
                plus  = $urandom_range(0, 1);
                minus = $urandom_range(0, 1);
            end
            if ($urandom_range(0, 5) == 0) fast = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) spin1_in = {~spin1_in[8], 8'($urandom)};
            else if ($urandom_range(0, 3) == 0) spin1_in[7:0] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) spin2_in = {~spin2_in[8], 8'($urandom)};
            step_cycle();
        end

        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
